clk_sel_ctrl: RTL and testbench

- Controls the clock selection for the ext/int clock mux: it qualifies the external clock by frequency measurement and lock status, then drives the mux `clk_int_select` input.
- Runs on the free-running internal reference clock (100 MHz). It counts edges of a toggle signal generated in the external clock domain.
- Adds qualification hysteresis, immediate fallback to internal, a hold-off period, and status and statistics outputs.

---
 rtl/clk_sel_ctrl_if.sv | 24 ++
 rtl/clk_sel_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_sel_ctrl_if.sv
// rtl/clk_sel_ctrl_if.sv - clock-select controller qualification inputs and mux/status outputs
interface clk_sel_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ext_toggle;
    logic             ext_locked;
    logic             force_int;
    logic             clk_int_select;
    logic             ext_freq_ok;
    logic [CNT_W-1:0] ext_count;
    logic             ext_selected;
    logic [7:0]       fallback_count;
    logic [1:0]       state;

    modport master (
        output ext_toggle, ext_locked, force_int,
        input  clk_int_select, ext_freq_ok, ext_count, ext_selected, fallback_count, state
    );

    modport slave (
        input  ext_toggle, ext_locked, force_int,
        output clk_int_select, ext_freq_ok, ext_count, ext_selected, fallback_count, state
    );
endinterface

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - qualifies the external clock by edge count and lock, drives the ext/int mux select
module clk_sel_ctrl #(
    parameter int WINDOW_CYCLES   = 1000,
    parameter int EXPECTED_CNT    = 400,
    parameter int TOL             = 8,
    parameter int QUAL_WINDOWS    = 4,
    parameter int HOLDOFF_WINDOWS = 16,
    parameter int CNT_W           = 16
) (
    input  logic         clk,
    input  logic         nrst,
    clk_sel_ctrl_if.slave bus
);

    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int QUAL_W = $clog2(QUAL_WINDOWS + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LO   = CNT_W'(EXPECTED_CNT - TOL);
    localparam logic [CNT_W-1:0]  CNT_HI   = CNT_W'(EXPECTED_CNT + TOL);
    localparam logic [QUAL_W-1:0] QUAL_MAX = QUAL_W'(QUAL_WINDOWS);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF_WINDOWS - 1);

    typedef enum logic [1:0] {
        INT_IDLE = 2'd0,
        QUAL     = 2'd1,
        EXT_RUN  = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

    logic [2:0]        tog_sync;
    logic [2:0]        lock_sync;
    logic              edge_det;
    logic              lock_ok;

    logic [WIN_W-1:0]  win_cnt;
    logic              window_end;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  win_total;
    logic              good_win;

    logic [CNT_W-1:0]  ext_count_q;
    logic              freq_ok_q;

    state_t            state, state_nxt;
    logic [QUAL_W-1:0] qual_cnt, qual_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              fb_inc;
    logic              sel_q;
    logic              ext_sel_q;
    logic [7:0]        fb_cnt;

    // Bit 0 is the first synchronizer stage; both inputs are fully asynchronous.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            tog_sync  <= '0;
            lock_sync <= '0;
        end else begin
            tog_sync  <= {tog_sync[1:0], bus.ext_toggle};
            lock_sync <= {lock_sync[1:0], bus.ext_locked};
        end
    end

    assign edge_det   = tog_sync[2] ^ tog_sync[1];
    assign lock_ok    = lock_sync[2];
    assign window_end = (win_cnt == WIN_LAST);

    // Running total including this cycle's edge, saturating at all-ones.
    assign win_total = (edge_det && !(&edge_cnt)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign good_win  = (win_total >= CNT_LO) && (win_total <= CNT_HI) && lock_ok;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            win_cnt     <= '0;
            edge_cnt    <= '0;
            ext_count_q <= '0;
            freq_ok_q   <= 1'b0;
        end else begin
            win_cnt <= window_end ? '0 : win_cnt + WIN_W'(1);
            if (window_end) begin
                edge_cnt    <= '0;
                ext_count_q <= win_total;
                freq_ok_q   <= good_win;
            end else begin
                edge_cnt    <= win_total;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        qual_nxt  = qual_cnt;
        hold_nxt  = hold_cnt;
        fb_inc    = 1'b0;
        case (state)
            INT_IDLE: begin
                if (window_end && good_win && !bus.force_int) begin
                    state_nxt = QUAL;
                    qual_nxt  = QUAL_W'(1);
                end
            end
            QUAL: begin
                if (bus.force_int) begin
                    state_nxt = INT_IDLE;
                    qual_nxt  = '0;
                end else if (window_end) begin
                    if (!good_win) begin
                        state_nxt = INT_IDLE;
                        qual_nxt  = '0;
                    end else if (qual_cnt + QUAL_W'(1) >= QUAL_MAX) begin
                        state_nxt = EXT_RUN;
                        qual_nxt  = '0;
                    end else begin
                        qual_nxt  = qual_cnt + QUAL_W'(1);
                    end
                end
            end
            EXT_RUN: begin
                // force_int wins over a simultaneous lock loss and is not a fallback.
                if (bus.force_int) begin
                    state_nxt = INT_IDLE;
                end else if (!lock_ok || (window_end && !good_win)) begin
                    state_nxt = HOLDOFF;
                    hold_nxt  = '0;
                    fb_inc    = 1'b1;
                end
            end
            HOLDOFF: begin
                if (window_end) begin
                    if (hold_cnt == HOLD_MAX) begin
                        state_nxt = INT_IDLE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: state_nxt = INT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= INT_IDLE;
            qual_cnt  <= '0;
            hold_cnt  <= '0;
            sel_q     <= 1'b1;
            ext_sel_q <= 1'b0;
            fb_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            qual_cnt  <= qual_nxt;
            hold_cnt  <= hold_nxt;
            sel_q     <= (state_nxt != EXT_RUN);
            ext_sel_q <= (state_nxt == EXT_RUN);
            if (fb_inc && (fb_cnt != 8'hFF)) begin
                fb_cnt <= fb_cnt + 8'd1;
            end
        end
    end

    assign bus.clk_int_select = sel_q;
    assign bus.ext_freq_ok    = freq_ok_q;
    assign bus.ext_count      = ext_count_q;
    assign bus.ext_selected   = ext_sel_q;
    assign bus.fallback_count = fb_cnt;
    assign bus.state          = state;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb/tb_clk_sel_ctrl.sv - directed self-checking bench for clk_sel_ctrl
module tb_clk_sel_ctrl;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   pos   = 0;
    int   edge_n = 0;

    int   ncnt[6] = '{0, 360, 391, 392, 408, 409};
    bit   nfrc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bit   ngood[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    clk_sel_ctrl_if ifa ();
    clk_sel_ctrl_if ifb ();

    clk_sel_ctrl dut_a (
        .clk (clk),
        .nrst(nrst),
        .bus (ifa)
    );

    clk_sel_ctrl #(
        .WINDOW_CYCLES  (8),
        .EXPECTED_CNT   (4),
        .TOL            (2),
        .QUAL_WINDOWS   (2),
        .HOLDOFF_WINDOWS(1),
        .CNT_W          (16)
    ) dut_b (
        .clk (clk),
        .nrst(nrst),
        .bus (ifb)
    );

    initial forever #5 clk = ~clk;

    // Reference copy of the 1000-cycle window position of dut_a.
    always @(posedge clk) begin
        if (!nrst) pos <= 0;
        else       pos <= (pos == 999) ? 0 : pos + 1;
    end

    // edge_n toggles per window, two cycles apart, all landing well inside the window.
    initial begin
        ifa.ext_toggle = 1'b0;
        forever begin
            @(negedge clk);
            if (pos < 2 * edge_n && pos % 2 == 0) ifa.ext_toggle = ~ifa.ext_toggle;
        end
    end

    initial begin
        ifb.ext_toggle = 1'b0;
        forever begin
            @(negedge clk);
            @(negedge clk);
            ifb.ext_toggle = ~ifb.ext_toggle;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_wend();
        do @(negedge clk); while (pos != 999);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        edge_n = 0;
        ifa.ext_locked = 1'b0;
        ifa.force_int  = 1'b0;
        ifb.ext_locked = 1'b0;
        ifb.force_int  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (ifa.state !== 2'd0 || ifa.clk_int_select !== 1'b1 || ifa.ext_selected !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: state=%0d sel=%b ext_sel=%b, required 0/1/0",
                     ifa.state, ifa.clk_int_select, ifa.ext_selected);
        end
        tests++;
        if (ifa.ext_count !== 16'd0 || ifa.ext_freq_ok !== 1'b0 || ifa.fallback_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_stat: count=%0d ok=%b fb=%0d, required 0/0/0",
                     ifa.ext_count, ifa.ext_freq_ok, ifa.fallback_count);
        end
        nrst = 1'b1;
    endtask

    task automatic test_qualify();
        ifa.ext_locked = 1'b1;
        edge_n = 400;
        wait_wend();
        tests++;
        if (ifa.state !== 2'd1 || ifa.ext_count !== 16'd400 || ifa.ext_freq_ok !== 1'b1 || ifa.clk_int_select !== 1'b1) begin
            fails++;
            $display("FAIL qual_first: state=%0d count=%0d ok=%b sel=%b, required 1/400/1/1",
                     ifa.state, ifa.ext_count, ifa.ext_freq_ok, ifa.clk_int_select);
        end
        for (int w = 2; w <= 3; w++) begin
            wait_wend();
            tests++;
            if (ifa.state !== 2'd1 || ifa.clk_int_select !== 1'b1) begin
                fails++;
                $display("FAIL qual_win%0d: state=%0d sel=%b, required 1/1", w, ifa.state, ifa.clk_int_select);
            end
        end
        wait_wend();
        tests++;
        if (ifa.state !== 2'd2 || ifa.clk_int_select !== 1'b0 || ifa.ext_selected !== 1'b1) begin
            fails++;
            $display("FAIL qual_ext: state=%0d sel=%b ext_sel=%b, required 2/0/1",
                     ifa.state, ifa.clk_int_select, ifa.ext_selected);
        end
    endtask

    task automatic test_fallback();
        int n;
        ifa.ext_locked = 1'b0;
        n = 0;
        while (n < 4 && ifa.state !== 2'd3) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (ifa.state !== 2'd3 || ifa.clk_int_select !== 1'b1 || ifa.fallback_count !== 8'd1 || ifa.ext_selected !== 1'b0) begin
            fails++;
            $display("FAIL lock_loss: state=%0d sel=%b fb=%0d ext_sel=%b after %0d clk, required 3/1/1/0 within 4",
                     ifa.state, ifa.clk_int_select, ifa.fallback_count, ifa.ext_selected, n);
        end
        repeat (15) wait_wend();
        tests++;
        if (ifa.state !== 2'd3 || ifa.ext_freq_ok !== 1'b0) begin
            fails++;
            $display("FAIL holdoff_15: state=%0d ok=%b, required 3/0", ifa.state, ifa.ext_freq_ok);
        end
        wait_wend();
        tests++;
        if (ifa.state !== 2'd0 || ifa.clk_int_select !== 1'b1) begin
            fails++;
            $display("FAIL holdoff_16: state=%0d sel=%b, required 0/1", ifa.state, ifa.clk_int_select);
        end
    endtask

    task automatic test_freq();
        ifa.ext_locked = 1'b1;
        for (int k = 0; k < 6; k++) begin
            edge_n = ncnt[k];
            ifa.force_int = nfrc[k];
            wait_wend();
            tests++;
            if (ifa.ext_count !== 16'(ncnt[k]) || ifa.ext_freq_ok !== ngood[k] || ifa.state !== 2'd0) begin
                fails++;
                $display("FAIL freq_%0d: count=%0d ok=%b state=%0d, required %0d/%b/0",
                         ncnt[k], ifa.ext_count, ifa.ext_freq_ok, ifa.state, ncnt[k], ngood[k]);
            end
        end
        ifa.force_int = 1'b0;
    endtask

    task automatic test_qual_abort();
        edge_n = 400;
        for (int w = 1; w <= 3; w++) begin
            wait_wend();
            tests++;
            if (ifa.state !== 2'd1 || ifa.clk_int_select !== 1'b1) begin
                fails++;
                $display("FAIL abort_good%0d: state=%0d sel=%b, required 1/1", w, ifa.state, ifa.clk_int_select);
            end
        end
        edge_n = 409;
        wait_wend();
        tests++;
        if (ifa.state !== 2'd0 || ifa.clk_int_select !== 1'b1 || ifa.ext_freq_ok !== 1'b0) begin
            fails++;
            $display("FAIL abort_bad: state=%0d sel=%b ok=%b, required 0/1/0",
                     ifa.state, ifa.clk_int_select, ifa.ext_freq_ok);
        end
        edge_n = 400;
        for (int w = 1; w <= 3; w++) begin
            wait_wend();
            tests++;
            if (ifa.state !== 2'd1 || ifa.clk_int_select !== 1'b1) begin
                fails++;
                $display("FAIL requal%0d: state=%0d sel=%b, required 1/1", w, ifa.state, ifa.clk_int_select);
            end
        end
        wait_wend();
        tests++;
        if (ifa.state !== 2'd2 || ifa.clk_int_select !== 1'b0) begin
            fails++;
            $display("FAIL requal_ext: state=%0d sel=%b, required 2/0", ifa.state, ifa.clk_int_select);
        end
    endtask

    task automatic test_force();
        ifa.force_int = 1'b1;
        @(posedge clk);
        #1;
        ifa.force_int = 1'b0;
        tests++;
        if (ifa.clk_int_select !== 1'b1 || ifa.state !== 2'd0 || ifa.fallback_count !== 8'd1 || ifa.ext_selected !== 1'b0) begin
            fails++;
            $display("FAIL force_int: sel=%b state=%0d fb=%0d ext_sel=%b, required 1/0/1/0",
                     ifa.clk_int_select, ifa.state, ifa.fallback_count, ifa.ext_selected);
        end
        repeat (4) wait_wend();
        tests++;
        if (ifa.state !== 2'd2) begin
            fails++;
            $display("FAIL force_requal: state=%0d, required 2", ifa.state);
        end
        repeat (300) @(posedge clk);
        #1;
        nrst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ifa.clk_int_select !== 1'b1 || ifa.state !== 2'd0 || ifa.ext_selected !== 1'b0 ||
            ifa.ext_freq_ok !== 1'b0 || ifa.ext_count !== 16'd0 || ifa.fallback_count !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset: sel=%b state=%0d ext_sel=%b ok=%b count=%0d fb=%0d, required 1/0/0/0/0/0",
                     ifa.clk_int_select, ifa.state, ifa.ext_selected, ifa.ext_freq_ok, ifa.ext_count, ifa.fallback_count);
        end
        nrst = 1'b1;
        edge_n = 0;
        ifa.ext_locked = 1'b0;
    endtask

    task automatic test_saturation();
        int n;
        int exp_fb;
        for (int i = 0; i < 300; i++) begin
            ifb.ext_locked = 1'b1;
            n = 0;
            while (n < 100 && ifb.state !== 2'd2) begin
                @(posedge clk);
                #1;
                n++;
            end
            tests++;
            if (ifb.state !== 2'd2) begin
                fails++;
                $display("FAIL sat_qual_timeout: iter=%0d state=%0d, required 2", i, ifb.state);
                break;
            end
            ifb.ext_locked = 1'b0;
            n = 0;
            while (n < 8 && ifb.state !== 2'd3) begin
                @(posedge clk);
                #1;
                n++;
            end
            exp_fb = (i + 1 > 255) ? 255 : i + 1;
            tests++;
            if (ifb.state !== 2'd3 || ifb.fallback_count !== 8'(exp_fb)) begin
                fails++;
                $display("FAIL sat_count: iter=%0d state=%0d fb=%0d, required 3/%0d", i, ifb.state, ifb.fallback_count, exp_fb);
                break;
            end
            n = 0;
            while (n < 40 && ifb.state !== 2'd0) begin
                @(posedge clk);
                #1;
                n++;
            end
            tests++;
            if (ifb.state !== 2'd0) begin
                fails++;
                $display("FAIL sat_holdoff_timeout: iter=%0d state=%0d, required 0", i, ifb.state);
                break;
            end
        end
    endtask

    initial begin
        ifa.ext_locked = 1'b0;
        ifa.force_int  = 1'b0;
        ifb.ext_locked = 1'b0;
        ifb.force_int  = 1'b0;
        test_reset();
        test_qualify();
        test_fallback();
        test_freq();
        test_qual_abort();
        test_force();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
